// File: rtl/global_pkg.sv
// Shared project types.
// Byte-wide datapath type used across the P03 design.
package global_pkg;

  typedef logic [7:0] data_t;

endpackage

// File: rtl/uart_ctrl_pkg.sv
// UART frame controller types and defaults.
// FSM encodings plus framing bytes and derived widths.
package uart_ctrl_pkg;

  localparam int MAX_LEN_DEF  = 8;
  localparam int TX_DEPTH_DEF = 8;

  localparam logic [7:0] SOF_DEF = 8'hFE;
  localparam logic [7:0] EOF_DEF = 8'hEF;

  typedef logic [$clog2(MAX_LEN_DEF+1)-1:0] len_t;
  typedef logic [$clog2(TX_DEPTH_DEF)-1:0]  ptr_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_LEN,
    R_CMD,
    R_PAY,
    R_EOF,
    R_HOLD
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_WAIT_HI,
    T_WAIT_LO
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Head is read combinationally; push and pop may coincide.
module uart_tx_fifo
  import global_pkg::*;
#(
  parameter int TX_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  data_t din_i,
  input  logic  pop_i,
  output data_t dout_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  data_t         mem_q [TX_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(TX_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  // Pointer and occupancy next-state; pointers wrap at depth.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame-level UART controller: RX frame parser with payload
// buffer and held command, TX byte queue paced on UART busy.
module uart_frame_ctrl
  import global_pkg::*;
  import uart_ctrl_pkg::*;
#(
  parameter int    MAX_LEN  = MAX_LEN_DEF,
  parameter int    TX_DEPTH = TX_DEPTH_DEF,
  parameter data_t SOF      = SOF_DEF,
  parameter data_t EOF      = EOF_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_interrupt,
  input  logic                         parity_err,
  input  data_t                        rx_data,
  output logic                         clear_interrupt,
  output logic                         transmit,
  output data_t                        tx_data,
  input  logic                         working,
  output logic                         cmd_valid,
  output logic [7:0]                   cmd,
  output logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         cmd_done,
  input  logic                         tx_push,
  input  logic [7:0]                   tx_byte,
  output logic                         tx_full,
  output logic                         tx_idle,
  output logic                         frame_err
);

  localparam int    LW        = $clog2(MAX_LEN+1);
  localparam int    AW        = $clog2(MAX_LEN);
  localparam data_t MAX_LEN_B = data_t'(MAX_LEN);

  rx_state_e     rx_q, rx_d;
  tx_state_e     tx_q, tx_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] idx_nx;
  data_t         cmd_q, cmd_d;
  data_t         pay_q [MAX_LEN];
  data_t         txd_q, txd_d;
  logic          clr_q;
  logic          err_q, err_d;
  logic          accept;
  logic          wr_en;
  logic          pop;
  logic          fifo_empty;
  data_t         fifo_dout;

  // A held interrupt is taken once; the clear pulse masks it.
  assign accept = rx_interrupt && !clr_q;
  assign idx_nx = idx_q + 1'b1;

  assign clear_interrupt = clr_q;
  assign frame_err       = err_q;
  assign cmd_valid       = (rx_q == R_HOLD);
  assign cmd             = cmd_q;
  assign cmd_len         = len_q;
  assign rd_data         = (32'(rd_addr) < MAX_LEN) ?
                           pay_q[rd_addr] : '0;
  assign transmit        = (tx_q == T_START);
  assign tx_data         = txd_q;
  assign tx_idle         = fifo_empty && (tx_q == T_IDLE);

  // RX frame parser next-state.
  always_comb begin
    rx_d  = rx_q;
    len_d = len_q;
    idx_d = idx_q;
    cmd_d = cmd_q;
    err_d = 1'b0;
    wr_en = 1'b0;
    if (accept) begin
      if (rx_q != R_HOLD && parity_err) begin
        err_d = 1'b1;
        rx_d  = R_IDLE;
      end else begin
        unique case (rx_q)
          R_IDLE: begin
            if (rx_data == SOF) rx_d = R_LEN;
          end
          R_LEN: begin
            if (rx_data > MAX_LEN_B) begin
              err_d = 1'b1;
              rx_d  = R_IDLE;
            end else begin
              len_d = rx_data[LW-1:0];
              idx_d = '0;
              rx_d  = R_CMD;
            end
          end
          R_CMD: begin
            cmd_d = rx_data;
            rx_d  = (len_q != '0) ? R_PAY : R_EOF;
          end
          R_PAY: begin
            wr_en = 1'b1;
            idx_d = idx_nx;
            if (idx_nx == len_q) rx_d = R_EOF;
          end
          R_EOF: begin
            if (rx_data == EOF) begin
              rx_d = R_HOLD;
            end else begin
              err_d = 1'b1;
              rx_d  = R_IDLE;
            end
          end
          R_HOLD: err_d = 1'b1;
          default: rx_d = R_IDLE;
        endcase
      end
    end
    if (rx_q == R_HOLD && cmd_done) rx_d = R_IDLE;
  end

  // RX registers, interrupt clear pulse and payload buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q  <= R_IDLE;
      len_q <= '0;
      idx_q <= '0;
      cmd_q <= '0;
      clr_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) pay_q[i] <= '0;
    end else begin
      rx_q  <= rx_d;
      len_q <= len_d;
      idx_q <= idx_d;
      cmd_q <= cmd_d;
      clr_q <= accept;
      err_q <= err_d;
      if (wr_en) pay_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

  uart_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (tx_byte),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (tx_full),
    .empty_o (fifo_empty)
  );

  // TX sequencer next-state: pop, pulse, wait busy high then low.
  always_comb begin
    tx_d  = tx_q;
    txd_d = txd_q;
    pop   = 1'b0;
    unique case (tx_q)
      T_IDLE: begin
        if (!fifo_empty && !working) begin
          pop   = 1'b1;
          txd_d = fifo_dout;
          tx_d  = T_START;
        end
      end
      T_START:   tx_d = T_WAIT_HI;
      T_WAIT_HI: if (working) tx_d = T_WAIT_LO;
      T_WAIT_LO: if (!working) tx_d = T_IDLE;
      default:   tx_d = T_IDLE;
    endcase
  end

  // TX sequencer state and outgoing byte register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q  <= T_IDLE;
      txd_q <= '0;
    end else begin
      tx_q  <= tx_d;
      txd_q <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a busy-flag UART model.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_frame_ctrl;
  import global_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_interrupt = 1'b0;
  logic       parity_err = 1'b0;
  data_t      rx_data = '0;
  logic       clear_interrupt;
  logic       transmit;
  data_t      tx_data;
  logic       working;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [3:0] cmd_len;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       cmd_done = 1'b0;
  logic       tx_push = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       tx_full;
  logic       tx_idle;
  logic       frame_err;

  logic       hold = 1'b0;
  logic       work_m = 1'b0;
  int         work_cnt = 0;
  int         tx_pulses = 0;
  int         busy_tx = 0;
  data_t      txq[$];
  int         clr_cnt = 0;
  int         err_cnt = 0;
  int         total = 0;
  int         passed = 0;

  assign working = hold | work_m;

  always #5 clk = ~clk;

  uart_frame_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rx_interrupt    (rx_interrupt),
    .parity_err      (parity_err),
    .rx_data         (rx_data),
    .clear_interrupt (clear_interrupt),
    .transmit        (transmit),
    .tx_data         (tx_data),
    .working         (working),
    .cmd_valid       (cmd_valid),
    .cmd             (cmd),
    .cmd_len         (cmd_len),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .cmd_done        (cmd_done),
    .tx_push         (tx_push),
    .tx_byte         (tx_byte),
    .tx_full         (tx_full),
    .tx_idle         (tx_idle),
    .frame_err       (frame_err)
  );

  // UART model: busy for 20 cycles after each transmit pulse.
  always @(negedge clk) begin
    if (transmit) begin
      tx_pulses++;
      if (working) busy_tx++;
      txq.push_back(tx_data);
      work_cnt = 20;
      work_m   = 1'b1;
    end else if (work_cnt > 0) begin
      work_cnt--;
      if (work_cnt == 0) work_m = 1'b0;
    end
  end

  // Pulse counters for interrupt clears and frame errors.
  always @(negedge clk) begin
    if (clear_interrupt) clr_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input data_t b, input logic pe);
    int n;
    rx_data = b;
    parity_err = pe;
    rx_interrupt = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clear_interrupt && n < 8);
    chk("clear_seen", clear_interrupt, 1);
    rx_interrupt = 1'b0;
    parity_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_q(input data_t q[$]);
    foreach (q[i]) send(q[i], 1'b0);
  endtask

  task automatic chk_rd(input logic [2:0] a, input data_t e);
    rd_addr = a;
    #1;
    chk("rd_data", rd_data, e);
  endtask

  task automatic chk_reset_outs();
    rd_addr = '0;
    #1;
    chk("rst_clear", clear_interrupt, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_idle", tx_idle, 1);
    chk("rst_frame_err", frame_err, 0);
  endtask

  initial begin
    int c0;
    int e0;
    int n;
    int p0;
    data_t q[$];

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    @(negedge clk);

    // Valid frame.
    c0 = clr_cnt;
    e0 = err_cnt;
    q = '{8'hFE, 8'h03, 8'hA5, 8'h11, 8'h22, 8'h33, 8'hEF};
    send_q(q);
    chk("clr_pulses", clr_cnt - c0, 7);
    chk("ok_no_err", err_cnt - e0, 0);
    chk("ok_valid", cmd_valid, 1);
    chk("ok_cmd", cmd, 8'hA5);
    chk("ok_len", cmd_len, 3);
    chk_rd(3'd0, 8'h11);
    chk_rd(3'd1, 8'h22);
    chk_rd(3'd2, 8'h33);

    // Byte while held.
    c0 = clr_cnt;
    e0 = err_cnt;
    send(8'h55, 1'b0);
    chk("hold_clr", clr_cnt - c0, 1);
    chk("hold_err", err_cnt - e0, 1);
    chk("hold_valid", cmd_valid, 1);
    chk("hold_cmd", cmd, 8'hA5);
    chk("hold_len", cmd_len, 3);
    chk_rd(3'd1, 8'h22);

    // Core releases the frame.
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("done_valid", cmd_valid, 0);

    // Oversized length, then an empty-payload frame.
    e0 = err_cnt;
    send(8'hFE, 1'b0);
    send(8'h09, 1'b0);
    chk("len_err", err_cnt - e0, 1);
    chk("len_valid", cmd_valid, 0);
    e0 = err_cnt;
    q = '{8'hFE, 8'h00, 8'h7C, 8'hEF};
    send_q(q);
    chk("zero_err", err_cnt - e0, 0);
    chk("zero_valid", cmd_valid, 1);
    chk("zero_cmd", cmd, 8'h7C);
    chk("zero_len", cmd_len, 0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("zero_done", cmd_valid, 0);

    // Bad EOF.
    e0 = err_cnt;
    q = '{8'hFE, 8'h01, 8'hB0, 8'h44, 8'h00};
    send_q(q);
    chk("eof_err", err_cnt - e0, 1);
    chk("eof_valid", cmd_valid, 0);

    // Parity error on payload byte.
    e0 = err_cnt;
    send(8'hFE, 1'b0);
    send(8'h01, 1'b0);
    send(8'hB0, 1'b0);
    send(8'h44, 1'b1);
    send(8'hEF, 1'b0);
    chk("par_err", err_cnt - e0, 1);
    chk("par_valid", cmd_valid, 0);

    // TX: fill FIFO while UART busy, overflow two bytes.
    hold = 1'b1;
    txq.delete();
    p0 = tx_pulses;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_push = 1'b1;
      tx_byte = 8'(i);
      @(negedge clk);
    end
    chk("tx_full", tx_full, 1);
    for (int i = 8; i < 10; i++) begin
      tx_byte = 8'(i);
      @(negedge clk);
    end
    tx_push = 1'b0;
    chk("tx_full_hold", tx_full, 1);
    chk("tx_not_idle", tx_idle, 0);
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_idle && !working) && n < 2000);
    chk("tx_drained", tx_idle && !working, 1);
    chk("tx_count", txq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("tx_byte_order", (i < txq.size()) ? txq[i] : 8'hXX,
          8'(i));
    end
    chk("tx_pulses", tx_pulses - p0, 8);
    chk("tx_while_busy", busy_tx, 0);
    chk("tx_full_after", tx_full, 0);

    // Reset mid-payload and mid-transmission.
    for (int i = 0; i < 3; i++) begin
      tx_push = 1'b1;
      tx_byte = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    tx_push = 1'b0;
    q = '{8'hFE, 8'h04, 8'hC1, 8'h01};
    send_q(q);
    chk("mid_busy", working, 1);
    chk("mid_not_idle", tx_idle, 0);
    rst = 1'b1;
    @(negedge clk);
    p0 = tx_pulses;
    chk_reset_outs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_tx", tx_pulses - p0, 0);
    chk("post_rst_idle", tx_idle, 1);
    e0 = err_cnt;
    q = '{8'hFE, 8'h02, 8'hD4, 8'hAA, 8'hBB, 8'hEF};
    send_q(q);
    chk("post_err", err_cnt - e0, 0);
    chk("post_valid", cmd_valid, 1);
    chk("post_cmd", cmd, 8'hD4);
    chk("post_len", cmd_len, 2);
    chk_rd(3'd0, 8'hAA);
    chk_rd(3'd1, 8'hBB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Frame-level controller that sequences the UART (rx_top/tx_top pair) for the P03 design.
- RX side: consumes received bytes, handshakes the RX interrupt, parses frames [SOF=0xFE, LEN, CMD, payload×LEN, EOF=0xEF] and stores the payload in a local buffer.
- Presents a command to the core datapath and holds it until the core acknowledges.
- TX side: queues response bytes from the core and feeds them one at a time to the UART transmitter, pacing on its busy flag.

Parameters:
- MAX_LEN, 8: maximum payload bytes per frame (buffer depth).
- TX_DEPTH, 8: TX byte FIFO depth (power of 2).
- SOF, 8'hFE: start-of-frame byte.
- EOF, 8'hEF: end-of-frame byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_interrupt  in  1  UART byte-received flag; held until cleared.
- parity_err  in  1  parity error for the byte flagged by rx_interrupt.
- rx_data  in  data_t (8)  received byte.
- clear_interrupt  out  1  one-cycle pulse that clears rx_interrupt.
- transmit  out  1  one-cycle pulse that starts a UART transmission.
- tx_data  out  data_t (8)  byte to send; stable from the transmit pulse until working falls.
- working  in  1  UART TX busy.
- cmd_valid  out  1  a complete, valid frame is held.
- cmd  out  8  command byte of the held frame.
- cmd_len  out  $clog2(MAX_LEN+1)  payload length of the held frame.
- rd_addr  in  $clog2(MAX_LEN)  payload read address.
- rd_data  out  8  payload byte at rd_addr (combinational read).
- cmd_done  in  1  core has finished with the held frame.
- tx_push  in  1  push tx_byte into the TX FIFO.
- tx_byte  in  8  response byte.
- tx_full  out  1  TX FIFO full.
- tx_idle  out  1  TX FIFO empty and TX FSM in T_IDLE.
- frame_err  out  1  one-cycle pulse on any dropped frame or byte.

Behaviour:
- Reset values: every output 0 except tx_idle=1. RX FSM and TX FSM both return to their idle states and the FIFO pointers clear. Reset takes effect mid-frame or mid-transmission with no further pulses issued.
- Byte acceptance:
  - A byte is accepted on a cycle where rx_interrupt=1 and clear_interrupt=0.
  - clear_interrupt is registered high for exactly the next cycle.
  - One byte is accepted per interrupt, and the FSM advances on that acceptance.
- RX FSM states are R_IDLE, R_LEN, R_CMD, R_PAY, R_EOF, R_HOLD.
  - R_IDLE: byte==SOF goes to R_LEN; any other byte is silently discarded.
  - R_LEN: latch the length. If LEN>MAX_LEN, pulse frame_err and go to R_IDLE. Otherwise go to R_CMD.
  - R_CMD: latch cmd. Go to R_PAY if LEN>0, else R_EOF.
  - R_PAY: write buf[idx], idx++. After the LEN-th byte, go to R_EOF.
  - R_EOF: byte==EOF goes to R_HOLD, with cmd_valid=1 from the next cycle. Otherwise pulse frame_err and go to R_IDLE.
  - R_HOLD:
    - cmd_valid, cmd, cmd_len and the buffer stay stable.
    - Bytes arriving in R_HOLD are still cleared, then dropped with a frame_err pulse.
    - cmd_done=1 clears cmd_valid in the next cycle and returns the FSM to R_IDLE.
    - cmd_done outside R_HOLD is ignored.
- Parity: if parity_err=1 on an accepted byte in any state other than R_HOLD, the byte is cleared, frame_err pulses, and the FSM goes to R_IDLE. A parity-errored SOF does not start a frame.
- TX FIFO:
  - Write on tx_push && !tx_full. A push while full is dropped, with no error pulse.
  - Simultaneous push and pop are both honoured.
  - Pointers wrap modulo TX_DEPTH, with an occupancy counter of width $clog2(TX_DEPTH)+1.
- TX FSM states are T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO.
  - T_IDLE: if the FIFO is non-empty and working=0, pop into the tx_data register and go to T_START.
  - T_START: transmit=1 for one cycle, then go to T_WAIT_HI.
  - T_WAIT_HI: wait for working=1, then go to T_WAIT_LO.
  - T_WAIT_LO: wait for working=0, then go to T_IDLE.
  - Minimum byte-to-byte gap is 2 cycles after working falls.
- tx_idle = FIFO empty AND TX FSM in T_IDLE.
- RX and TX paths are independent and may be active in the same cycle.

Decomposition:
- uart_ctrl_pkg holds:
  - rx_state_e and tx_state_e enums.
  - SOF and EOF defaults.
  - The len_t and ptr_t widths derived from MAX_LEN and TX_DEPTH.
- data_t is reused from global_pkg.
- One sub-module: uart_tx_fifo (synchronous FIFO, push/pop/full/empty, parameter TX_DEPTH).

Test Plan:
- Valid frame FE 03 A5 11 22 33 EF. Required response:
  - Exactly one clear_interrupt pulse per byte.
  - cmd_valid=1, cmd=A5, cmd_len=3, with rd_addr 0/1/2 returning 11/22/33.
  - cmd_done pulse drops cmd_valid the next cycle.
- Frame FE 09 ... (LEN>MAX_LEN=8) -> frame_err pulse after the LEN byte; subsequent FE 00 7C EF is accepted with cmd=7C, cmd_len=0.
- Bad EOF and parity:
  - FE 01 B0 44 00 -> frame_err pulse, no cmd_valid.
  - FE 01 B0 44 EF with parity_err on 44 -> frame_err, no cmd_valid.
- Bytes received while in R_HOLD (e.g. 55) -> byte cleared, frame_err pulse, held cmd and buffer unchanged.
- Push 10 bytes 0x00..0x09 back-to-back with TX_DEPTH=8. Required response:
  - tx_full asserts and the last 2 bytes are dropped.
  - The UART model (working high 20 cycles after transmit) sees tx_data 00..07 in order, one transmit pulse each, none while working=1.
- Assert rst mid-payload and mid-transmission -> all outputs return to reset values next cycle, tx_idle=1, and the next full frame parses correctly.
